// File: rtl/fifo_stim_src_pkg.sv
// Shared constants, FSM state encoding and seed helper for the ap_fifo stimulus source.
package fifo_stim_pkg;

  localparam int          LANE_W    = 32;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FINISH} state_t;

  // Lane k seed is SEED + k; an all-zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = seed + 32'(k);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/fifo_stim_src_if.sv
// Kernel-facing ap_ctrl_hs handshake plus the parallel ap_fifo read ports.
interface fifo_stim_src_if #(
  parameter int LANES = 8
);
  import fifo_stim_pkg::*;

  logic                    ap_start;
  logic                    ap_ready;
  logic                    ap_done;
  logic [LANES*LANE_W-1:0] din;
  logic [LANES-1:0]        empty_n;
  logic [LANES-1:0]        read;

  modport master (
    output ap_start, din, empty_n,
    input  ap_ready, ap_done, read
  );

  modport slave (
    input  ap_start, din, empty_n,
    output ap_ready, ap_done, read
  );

endinterface

// File: rtl/fifo_stim_src_lane.sv
// One FWFT lane: Galois LFSR head word, word counter, empty_n and underflow detect.
module stim_lane
  import fifo_stim_pkg::*;
#(
  parameter logic [31:0] LANE_SEED     = 32'h1,
  parameter int          WORDS_PER_RUN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic              read,
  output logic [LANE_W-1:0] din,
  output logic              empty_n,
  output logic              underflow
);

  localparam int               CNT_W = $clog2(WORDS_PER_RUN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS_PER_RUN - 1);

  logic [LANE_W-1:0] lfsr;
  logic [CNT_W-1:0]  cnt;

  function automatic logic [LANE_W-1:0] lfsr_next(input logic [LANE_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  // A reload owns the cycle, so a concurrent read is neither served nor flagged.
  assign underflow = read && !empty_n && !load;
  assign din       = lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= '0;
      cnt     <= '0;
      empty_n <= 1'b0;
    end else if (load) begin
      lfsr    <= LANE_SEED;
      cnt     <= '0;
      empty_n <= 1'b1;
    end else if (clr) begin
      empty_n <= 1'b0;
    end else if (read && empty_n) begin
      cnt <= cnt + 1'b1;
      // The last word stays on din after the lane runs dry.
      if (cnt == LAST) empty_n <= 1'b0;
      else             lfsr    <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/fifo_stim_src.sv
// Stimulus source top: run sequencing FSM, run counter, sticky error flags, LANES FWFT lanes.
module fifo_stim_src
  import fifo_stim_pkg::*;
#(
  parameter int          LANES         = 8,
  parameter int          WORDS_PER_RUN = 1024,
  parameter int          NUM_RUNS      = 2,
  parameter logic [31:0] SEED          = 32'h0000_0001
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  fifo_stim_src_if.master        bus,
  output logic [7:0]             run_cnt,
  output logic                   all_done,
  output logic                   err_underflow,
  output logic                   err_short
);

  state_t                  state;
  logic                    start_r;
  logic                    load;
  logic                    last_run;
  logic                    finish_go;
  logic [LANES-1:0]        empty_w;
  logic [LANES-1:0]        uf_w;
  logic [LANES*LANE_W-1:0] din_w;

  assign load      = (state == LOAD);
  assign last_run  = ((run_cnt + 8'd1) == 8'(NUM_RUNS));
  // Lanes are emptied on the same edge that enters FINISH so empty_n and all_done move together.
  assign finish_go = (state == RUN) && bus.ap_done && last_run;

  assign bus.ap_start = start_r;
  assign bus.empty_n  = empty_w;
  assign bus.din      = din_w;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    stim_lane #(
      .LANE_SEED     (lane_seed(SEED, k)),
      .WORDS_PER_RUN (WORDS_PER_RUN)
    ) u_lane (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .load      (load),
      .clr       (finish_go),
      .read      (bus.read[k]),
      .din       (din_w[k*LANE_W +: LANE_W]),
      .empty_n   (empty_w[k]),
      .underflow (uf_w[k])
    );
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      start_r       <= 1'b0;
      run_cnt       <= '0;
      all_done      <= 1'b0;
      err_underflow <= 1'b0;
      err_short     <= 1'b0;
    end else begin
      if (|uf_w) err_underflow <= 1'b1;
      case (state)
        IDLE:  state <= LOAD;
        LOAD: begin
          state   <= START;
          start_r <= 1'b1;
        end
        START: begin
          if (bus.ap_ready) begin
            start_r <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          // ap_done in any other state is deliberately ignored.
          if (bus.ap_done) begin
            run_cnt <= run_cnt + 8'd1;
            if (|empty_w) err_short <= 1'b1;
            if (last_run) begin
              state    <= FINISH;
              all_done <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        FINISH: begin
          all_done <= 1'b1;
          start_r  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stim_src.sv
// Directed bench for fifo_stim_src with LANES=2, WORDS_PER_RUN=4, NUM_RUNS=2, SEED=1.
module tb_fifo_stim_src;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] run_cnt;
  logic       all_done, err_underflow, err_short;
  int         n_chk = 0;
  int         n_bad = 0;

  logic [31:0] exp0 [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
  logic [31:0] exp1 [4] = '{32'h0000_0002, 32'h0000_0001, 32'h8020_0003, 32'hC030_0002};

  fifo_stim_src_if #(.LANES(2)) bus ();

  fifo_stim_src #(
    .LANES         (2),
    .WORDS_PER_RUN (4),
    .NUM_RUNS      (2),
    .SEED          (32'h0000_0001)
  ) dut (
    .ap_clk        (clk),
    .ap_rst_n      (rst_n),
    .bus           (bus.master),
    .run_cnt       (run_cnt),
    .all_done      (all_done),
    .err_underflow (err_underflow),
    .err_short     (err_short)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.read = '0; bus.ap_ready = 1'b0; bus.ap_done = 1'b0;
    #1;
    chk("rst_start", {31'b0, bus.ap_start}, 32'h0);
    chk("rst_empty", {30'b0, bus.empty_n}, 32'h0);
    chk("rst_din0", bus.din[31:0], 32'h0);
    chk("rst_din1", bus.din[63:32], 32'h0);
    chk("rst_runcnt", {24'b0, run_cnt}, 32'h0);
    chk("rst_flags", {29'b0, all_done, err_underflow, err_short}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!(bus.empty_n == 2'b11 && bus.ap_start) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {31'b0, (bus.empty_n == 2'b11 && bus.ap_start)}, 32'h1);
  endtask

  task automatic drain_both(input int run);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r%0d_din0_%0d", run, i), bus.din[31:0], exp0[i]);
      chk($sformatf("r%0d_din1_%0d", run, i), bus.din[63:32], exp1[i]);
      chk($sformatf("r%0d_empty_%0d", run, i), {30'b0, bus.empty_n}, 32'h3);
      bus.ap_ready = (i == 0);
      bus.read     = 2'b11;
      @(negedge clk);
    end
    bus.read = '0; bus.ap_ready = 1'b0;
    chk($sformatf("r%0d_drained", run), {30'b0, bus.empty_n}, 32'h0);
    chk($sformatf("r%0d_hold0", run), bus.din[31:0], 32'h6018_0001);
    chk($sformatf("r%0d_start_low", run), {31'b0, bus.ap_start}, 32'h0);
    bus.ap_done = 1'b1;
    @(negedge clk);
    bus.ap_done = 1'b0;
    chk($sformatf("r%0d_runcnt", run), {24'b0, run_cnt}, 32'(run));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.read = '0; bus.ap_ready = 1'b0; bus.ap_done = 1'b0;
    @(negedge clk);

    // Two complete runs with every-cycle reads.
    do_reset();
    wait_start();
    drain_both(1);
    wait_start();
    drain_both(2);
    chk("fin_all_done", {31'b0, all_done}, 32'h1);
    chk("fin_empty", {30'b0, bus.empty_n}, 32'h0);
    chk("fin_start", {31'b0, bus.ap_start}, 32'h0);
    chk("fin_errs", {30'b0, err_underflow, err_short}, 32'h0);
    repeat (3) @(negedge clk);
    chk("fin_sticky", {31'b0, all_done}, 32'h1);

    // Delayed ap_ready, then underflow on an exhausted lane 0.
    do_reset();
    wait_start();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_start_%0d", i), {31'b0, bus.ap_start}, 32'h1);
      @(negedge clk);
    end
    bus.ap_ready = 1'b1;
    @(negedge clk);
    bus.ap_ready = 1'b0;
    chk("start_drop", {31'b0, bus.ap_start}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("l0_din_%0d", i), bus.din[31:0], exp0[i]);
      bus.read = 2'b01;
      @(negedge clk);
    end
    chk("l0_empty", {30'b0, bus.empty_n}, 32'h2);
    chk("uf_before", {31'b0, err_underflow}, 32'h0);
    @(negedge clk);
    bus.read = '0;
    chk("uf_set", {31'b0, err_underflow}, 32'h1);
    chk("uf_din0", bus.din[31:0], 32'h6018_0001);
    chk("uf_din1", bus.din[63:32], 32'h0000_0002);
    chk("uf_empty", {30'b0, bus.empty_n}, 32'h2);
    chk("uf_short", {31'b0, err_short}, 32'h0);

    // Early ap_done after two lane-0 reads.
    do_reset();
    wait_start();
    bus.ap_ready = 1'b1; bus.read = 2'b01;
    @(negedge clk);
    bus.ap_ready = 1'b0;
    @(negedge clk);
    bus.read = '0;
    chk("short_din0", bus.din[31:0], 32'hC030_0002);
    bus.ap_done = 1'b1;
    @(negedge clk);
    bus.ap_done = 1'b0;
    chk("short_set", {31'b0, err_short}, 32'h1);
    chk("short_runcnt", {24'b0, run_cnt}, 32'h1);
    @(negedge clk);
    chk("short_reload0", bus.din[31:0], 32'h0000_0001);
    chk("short_empty", {30'b0, bus.empty_n}, 32'h3);
    chk("short_start", {31'b0, bus.ap_start}, 32'h1);

    // Reset asserted in the middle of the second run.
    bus.ap_ready = 1'b1; bus.read = 2'b01;
    @(negedge clk);
    bus.ap_ready = 1'b0;
    @(negedge clk);
    bus.read = '0;
    chk("mid_din0", bus.din[31:0], 32'hC030_0002);
    do_reset();
    wait_start();
    chk("mid_reload0", bus.din[31:0], 32'h0000_0001);
    chk("mid_runcnt", {24'b0, run_cnt}, 32'h0);
    chk("mid_flags", {30'b0, err_underflow, err_short}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
